instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Automatic control source for the 16-bit datapath. It replaces the switch-driven manual control bundle. It accepts one 16-bit instruction per start/done handshake, decodes it, and drives readnum, loada, loadb, shift, asel, bsel, ALUop, loadc, loads, writenum, write, vsel and datapath_in through the register-read, execute and writeback stages. It sits between an instruction source (memory or a switch latch) and the datapath.

Parameters:
W, 16, datapath_in width; imm8 is sign-extended to W bits.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request: latch instr and execute; sampled only in WAIT
instr  input  16  instruction word, sampled on the start edge
busy  output  1  high in every state except WAIT
done  output  1  one-cycle pulse: instruction retired
illegal  output  1  qualifies done: undefined encoding; held until next start
readnum  output  3  register file read address
writenum  output  3  register file write address
write  output  1  register file write enable
vsel  output  1  1 selects datapath_in, 0 selects C for writeback
loada  output  1  load A
loadb  output  1  load B
shift  output  2  shifter control
asel  output  1  1 forces A operand to 0
bsel  output  1  B operand select; always 0
ALUop  output  2  00 ADD, 01 SUB, 10 AND, 11 NOT B
loadc  output  1  load C
loads  output  1  load status
datapath_in  output  W  sign-extended imm8 of the latched instruction, stable while busy

Behaviour:
- Reset (async, reset_n=0): state=WAIT; instruction register=0; done=0; illegal=0; all control outputs=0; datapath_in=0. Reset mid-instruction aborts it immediately, with no further writes.
- Instruction fields:
  - opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
  - Legal: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN. All other encodings are illegal.
- States (Moore; control outputs decoded from state + latched instr; one cycle each):
  - WAIT: idle.
  - DECODE: no controls asserted.
  - GETA: readnum=Rn, loada=1.
  - GETB: readnum=Rm, loadb=1.
  - EXEC:
    - shift=sh; ALUop from op (MOV reg uses 00).
    - asel=1 for MOV reg and MVN, else 0.
    - loadc=1 except CMP; loads=1 for CMP only.
  - WRREG: writenum=Rd, write=1, vsel=0.
  - WRIMM: writenum=Rn, write=1, vsel=1.
- Unlisted outputs are 0 in each state.
- Transitions:
  - WAIT: start=1 latches instr and goes to DECODE.
  - DECODE: MOV imm goes to WRIMM; ADD/AND/CMP go to GETA; MOV reg/MVN go to GETB; illegal goes to WAIT.
  - GETA goes to GETB. GETB goes to EXEC.
  - EXEC: CMP goes to WAIT; otherwise WRREG.
  - WRREG and WRIMM go to WAIT.
- done is registered and high for exactly the first WAIT cycle after retirement. illegal is set together with done for an illegal encoding.
- Busy cycles (start edge to done): MOV imm 2; MOV reg/MVN 4; CMP 4; ADD/AND 5; illegal 1.
- start while busy is ignored; instr is not re-sampled.
- start held high in WAIT launches back-to-back instructions, including in the done cycle.
- write is never asserted for CMP or illegal encodings.

Optional Feature:
SEQ_STEP_EN:
- Defined: adds input port step (1 bit). Every non-WAIT state holds, with outputs frozen, until a cycle with step=1. WAIT→DECODE still needs only start.
- Undefined: the step port is absent and the FSM advances every cycle as above.

Test Plan:
- Reset, then start with instr=0xD007 (MOV R0,#7) → DECODE, then WRIMM with write=1, writenum=0, vsel=1, datapath_in=0x0007; done=1 on the next cycle; busy high for 2 cycles.
- instr=0xD1FE (MOV R1,#-2) → WRIMM with writenum=1, datapath_in=0xFFFE.
- instr=0xA148 (ADD R2,R1,R0 LSL1):
  - GETA: readnum=1, loada=1. GETB: readnum=0, loadb=1.
  - EXEC: shift=01, ALUop=00, asel=0, loadc=1. WRREG: writenum=2, write=1, vsel=0.
  - done after 5 busy cycles.
- instr=0xA900 (CMP R1,R0) → EXEC with ALUop=01, loads=1, loadc=0; write stays 0 throughout; done after 4 cycles.
- instr=0xB860 (MVN R3,R0) → no GETA; EXEC with asel=1, ALUop=11; WRREG writenum=3.
- Boundary cases:
  - instr=0x0000 → done=1 and illegal=1 after 1 busy cycle; no load or write.
  - Second start during ADD is ignored.
  - reset_n pulled low during EXEC of ADD → outputs 0 immediately; no WRREG occurs.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer that drives the 16-bit datapath control bundle.
// Optional build macro SEQ_STEP_EN adds a step input that gates every non-WAIT state.
module instr_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
`ifdef SEQ_STEP_EN
    input  logic         step,
`endif
    input  logic         start,
    input  logic [15:0]  instr,
    output logic         busy,
    output logic         done,
    output logic         illegal,
    output logic [2:0]   readnum,
    output logic [2:0]   writenum,
    output logic         write,
    output logic         vsel,
    output logic         loada,
    output logic         loadb,
    output logic [1:0]   shift,
    output logic         asel,
    output logic         bsel,
    output logic [1:0]   ALUop,
    output logic         loadc,
    output logic         loads,
    output logic [W-1:0] datapath_in
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GETA,
        S_GETB,
        S_EXEC,
        S_WRREG,
        S_WRIMM
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_instr;
    logic        r_done;
    logic        r_illegal;
    logic        w_advance;

`ifdef SEQ_STEP_EN
    assign w_advance = step;
`else
    assign w_advance = 1'b1;
`endif

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;
    logic       w_is_movi;
    logic       w_is_movr;
    logic       w_is_alu;
    logic       w_is_cmp;
    logic       w_is_mvn;
    logic       w_legal;

    assign w_opcode  = r_instr[15:13];
    assign w_op      = r_instr[12:11];
    assign w_rn      = r_instr[10:8];
    assign w_rd      = r_instr[7:5];
    assign w_sh      = r_instr[4:3];
    assign w_rm      = r_instr[2:0];
    assign w_is_movi = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_is_movr = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_is_alu  = (w_opcode == 3'b101);
    assign w_is_cmp  = w_is_alu && (w_op == 2'b01);
    assign w_is_mvn  = w_is_alu && (w_op == 2'b11);
    assign w_legal   = w_is_movi || w_is_movr || w_is_alu;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        readnum      = 3'd0;
        writenum     = 3'd0;
        write        = 1'b0;
        vsel         = 1'b0;
        loada        = 1'b0;
        loadb        = 1'b0;
        shift        = 2'b00;
        asel         = 1'b0;
        bsel         = 1'b0;
        ALUop        = 2'b00;
        loadc        = 1'b0;
        loads        = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (start) w_state_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_advance) begin
                    if (!w_legal)                   w_state_next = S_WAIT;
                    else if (w_is_movi)             w_state_next = S_WRIMM;
                    else if (w_is_movr || w_is_mvn) w_state_next = S_GETB;
                    else                            w_state_next = S_GETA;
                end
            end
            S_GETA: begin
                readnum = w_rn;
                loada   = 1'b1;
                if (w_advance) w_state_next = S_GETB;
            end
            S_GETB: begin
                readnum = w_rm;
                loadb   = 1'b1;
                if (w_advance) w_state_next = S_EXEC;
            end
            S_EXEC: begin
                shift = w_sh;
                ALUop = w_is_movr ? 2'b00 : w_op;
                asel  = w_is_movr || w_is_mvn;
                loadc = !w_is_cmp;
                loads = w_is_cmp;
                if (w_advance) w_state_next = w_is_cmp ? S_WAIT : S_WRREG;
            end
            S_WRREG: begin
                writenum = w_rd;
                write    = 1'b1;
                if (w_advance) w_state_next = S_WAIT;
            end
            S_WRIMM: begin
                writenum = w_rn;
                write    = 1'b1;
                vsel     = 1'b1;
                if (w_advance) w_state_next = S_WAIT;
            end
            default: w_state_next = S_WAIT;
        endcase
    end

    // Instruction latch plus the retirement flags; illegal stays up until the next accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr   <= 16'h0000;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done <= (r_state != S_WAIT) && (w_state_next == S_WAIT);
            if (r_state == S_WAIT && start) begin
                r_instr   <= instr;
                r_illegal <= 1'b0;
            end else if (r_state == S_DECODE && w_advance && !w_legal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign busy        = (r_state != S_WAIT);
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign datapath_in = {{(W-8){r_instr[7]}}, r_instr[7:0]};

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer: one block per instruction class
// plus illegal encoding, ignored start, back-to-back launch and mid-instruction reset.
module tb_instr_sequencer;

    localparam int W = 16;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [15:0]  instr;
    logic         busy, done, illegal, write, vsel, loada, loadb, asel, bsel, loadc, loads;
    logic [2:0]   readnum, writenum;
    logic [1:0]   shift, ALUop;
    logic [W-1:0] datapath_in;

    int n_checks = 0;
    int n_errors = 0;

    instr_sequencer #(.W(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef SEQ_STEP_EN
        .step        (1'b1),
`endif
        .start       (start),
        .instr       (instr),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .readnum     (readnum),
        .writenum    (writenum),
        .write       (write),
        .vsel        (vsel),
        .loada       (loada),
        .loadb       (loadb),
        .shift       (shift),
        .asel        (asel),
        .bsel        (bsel),
        .ALUop       (ALUop),
        .loadc       (loadc),
        .loads       (loads),
        .datapath_in (datapath_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply start for one edge; returns at the negedge where the DUT sits in DECODE.
    task automatic issue(input logic [15:0] word);
        start = 1'b1;
        instr = word;
        @(negedge clk);
        start = 1'b0;
        instr = 16'h0000;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        instr   = 16'h0000;
        #12;
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_ill",   illegal, 0);
        check("rst_write", write, 0);
        check("rst_loada", loada, 0);
        check("rst_dpin",  datapath_in, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // MOV R0,#7
        issue(16'hD007);
        check("movi0_dec_busy",  busy, 1);
        check("movi0_dec_write", write, 0);
        @(negedge clk);
        check("movi0_wr_write", write, 1);
        check("movi0_wr_num",   writenum, 0);
        check("movi0_wr_vsel",  vsel, 1);
        check("movi0_wr_dpin",  datapath_in, 16'h0007);
        check("movi0_wr_busy",  busy, 1);
        @(negedge clk);
        check("movi0_done", done, 1);
        check("movi0_busy", busy, 0);
        check("movi0_ill",  illegal, 0);
        @(negedge clk);
        check("movi0_done_pulse", done, 0);

        // MOV R1,#-2
        issue(16'hD1FE);
        @(negedge clk);
        check("movi1_num",  writenum, 1);
        check("movi1_dpin", datapath_in, 16'hFFFE);
        @(negedge clk);
        check("movi1_done", done, 1);

        // ADD R2,R1,R0 LSL1 with a second start thrown in during GETA
        issue(16'hA148);
        check("add_dec_loada", loada, 0);
        @(negedge clk);
        check("add_geta_rn",  readnum, 1);
        check("add_geta_lda", loada, 1);
        start = 1'b1;
        instr = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        check("add_getb_rm",  readnum, 0);
        check("add_getb_ldb", loadb, 1);
        check("add_getb_lda", loada, 0);
        @(negedge clk);
        check("add_ex_shift", shift, 2'b01);
        check("add_ex_alu",   ALUop, 2'b00);
        check("add_ex_asel",  asel, 0);
        check("add_ex_loadc", loadc, 1);
        check("add_ex_loads", loads, 0);
        check("add_ex_bsel",  bsel, 0);
        @(negedge clk);
        check("add_wr_num",   writenum, 2);
        check("add_wr_write", write, 1);
        check("add_wr_vsel",  vsel, 0);
        check("add_wr_busy",  busy, 1);
        @(negedge clk);
        check("add_done", done, 1);
        check("add_busy", busy, 0);
        check("add_ill",  illegal, 0);
        @(negedge clk);
        check("add_no_relaunch", busy, 0);

        // CMP R1,R0: count busy cycles and watch write throughout
        begin
            int cyc;
            logic wseen;
            cyc   = 0;
            wseen = 1'b0;
            issue(16'hA900);
            while (busy && cyc < 20) begin
                cyc++;
                wseen = wseen | write;
                if (cyc == 4) begin
                    check("cmp_ex_alu",   ALUop, 2'b01);
                    check("cmp_ex_loads", loads, 1);
                    check("cmp_ex_loadc", loadc, 0);
                end
                @(negedge clk);
            end
            check("cmp_cycles", cyc, 4);
            check("cmp_write",  wseen, 0);
            check("cmp_done",   done, 1);
        end

        // MVN R3,R0: skips GETA
        issue(16'hB860);
        check("mvn_dec_lda", loada, 0);
        @(negedge clk);
        check("mvn_getb_ldb", loadb, 1);
        check("mvn_getb_lda", loada, 0);
        @(negedge clk);
        check("mvn_ex_asel", asel, 1);
        check("mvn_ex_alu",  ALUop, 2'b11);
        check("mvn_ex_ldc",  loadc, 1);
        @(negedge clk);
        check("mvn_wr_num",   writenum, 3);
        check("mvn_wr_write", write, 1);
        @(negedge clk);
        check("mvn_done", done, 1);

        // Illegal 0x0000
        issue(16'h0000);
        check("ill_dec_busy",  busy, 1);
        check("ill_dec_write", write, 0);
        check("ill_dec_load",  {loada, loadb, loadc, loads}, 0);
        @(negedge clk);
        check("ill_done", done, 1);
        check("ill_flag", illegal, 1);
        check("ill_busy", busy, 0);
        @(negedge clk);
        check("ill_done_pulse", done, 0);
        check("ill_held",       illegal, 1);

        // Back-to-back: start held high across the done cycle; also clears illegal
        start = 1'b1;
        instr = 16'hD203;
        @(negedge clk);
        check("b2b_ill_clr", illegal, 0);
        @(negedge clk);
        check("b2b_wr_num",  writenum, 2);
        check("b2b_wr_dpin", datapath_in, 16'h0003);
        @(negedge clk);
        check("b2b_done",   done, 1);
        check("b2b_idle",   busy, 0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_relaunch", busy, 1);
        check("b2b_done_clr", done, 0);
        @(negedge clk);
        @(negedge clk);
        check("b2b2_done", done, 1);

        // Reset asserted during EXEC of ADD
        issue(16'hA148);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst_ex_loadc_pre", loadc, 1);
        reset_n = 1'b0;
        #1;
        check("rst_ex_loadc", loadc, 0);
        check("rst_ex_busy",  busy, 0);
        check("rst_ex_dpin",  datapath_in, 0);
        @(negedge clk);
        check("rst_ex_write", write, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_after_write", write, 0);
        check("rst_after_busy",  busy, 0);
        check("rst_after_done",  done, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
